// File: rtl/cselector_pkg.sv
// Shared types and helpers for the N-way token selectors on the
// cache-replacement control path.
package cselector_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DELAY     = 2'd1,
    WAIT_FREE = 2'd2
  } state_e;

  localparam int SEL_MULTICAST = 0;
  localparam int SEL_RR        = 1;

  // Width needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational rotate-and-priority arbiter: grants the first set request
// at or above i_ptr, wrapping past N-1 back to 0.
module rr_pick_onehot
  import cselector_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_index,
  output logic          o_any
);

  logic [PW-1:0] w_idx;

  // NOTE: every output gets a default before the loop so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_index        = w_idx;
      end
    end
  end

endmodule

// File: rtl/cselector_n_sync.sv
// Synchronous N-way token selector: accepts a drive token, waits DELAY
// cycles, drives the selected channels, then collects their frees.
module cselector_n_sync
  import cselector_pkg::state_e, cselector_pkg::IDLE, cselector_pkg::WAIT_FREE,
         cselector_pkg::SEL_RR, cselector_pkg::clog2;
#(
  parameter int N         = 4,
  parameter int DELAY     = 4,
  parameter int SEL_MODE  = 0,
  parameter int FREE_JOIN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_drive,
  input  logic [N-1:0] i_valid,
  output logic         o_ready,
  output logic         o_fire,
  output logic         o_free,
  output logic [N-1:0] o_driveNext,
  input  logic [N-1:0] i_freeNext,
  output logic         o_drop,
  output logic         o_err
);

  localparam int PW = clog2(N);
  localparam int CW = clog2(DELAY + 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sel;
  logic [N-1:0]  r_pend;
  logic [N-1:0]  r_drive_next;
  logic [PW-1:0] r_rr;
  logic          r_ready;
  logic          r_fire;
  logic          r_drop;
  logic          r_err;

  logic [N-1:0]  w_rr_grant;
  logic [N-1:0]  w_sel;
  logic [N-1:0]  w_window;
  logic [N-1:0]  w_rem;
  logic [PW-1:0] w_rr_idx;
  logic [PW-1:0] w_rr_next;
  logic          w_rr_any;
  logic          w_accept;
  logic          w_done;
  logic          w_err_set;

  rr_pick_onehot #(.N(N)) u_pick (
    .i_req   (i_valid),
    .i_ptr   (r_rr),
    .o_grant (w_rr_grant),
    .o_index (w_rr_idx),
    .o_any   (w_rr_any)
  );

  assign w_sel     = (SEL_MODE == SEL_RR) ? w_rr_grant : i_valid;
  assign w_rr_next = (w_rr_idx == PW'(N - 1)) ? '0 : w_rr_idx + 1'b1;
  assign w_accept  = i_drive & r_ready;

  // Downstream cannot answer in the cycle it first sees driveNext, so the
  // free window opens one cycle later; anything outside it is an error.
  assign w_window  = (r_state == WAIT_FREE && r_drive_next == '0) ? r_pend : '0;
  assign w_rem     = w_window & ~i_freeNext;
  assign w_done    = (w_window != '0) &&
                     ((FREE_JOIN != 0) ? (w_rem == '0) : ((w_window & i_freeNext) != '0));
  assign w_err_set = (i_drive & ~r_ready) | ((i_freeNext & ~w_window) != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_pend       <= '0;
      r_drive_next <= '0;
      r_rr         <= '0;
      r_ready      <= 1'b0;
      r_fire       <= 1'b0;
      r_drop       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_fire       <= 1'b0;
      r_drop       <= 1'b0;
      r_drive_next <= '0;
      if (w_err_set) r_err <= 1'b1;

      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            r_fire  <= 1'b1;
            r_sel   <= w_sel;
            if (SEL_MODE == SEL_RR && w_rr_any) r_rr <= w_rr_next;
            if (w_sel == '0) begin
              r_drop <= 1'b1;
            end else begin
              r_state <= cselector_pkg::DELAY;
              r_cnt   <= CW'(DELAY - 1);
            end
          end
        end

        cselector_pkg::DELAY: begin
          if (r_cnt == '0) begin
            r_drive_next <= r_sel;
            r_pend       <= r_sel;
            r_state      <= WAIT_FREE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        WAIT_FREE: begin
          if (w_window != '0) begin
            r_pend <= w_rem;
            if (w_done) begin
              r_pend  <= '0;
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_fire      = r_fire;
  assign o_free      = r_fire;
  assign o_driveNext = r_drive_next;
  assign o_drop      = r_drop;
  assign o_err       = r_err;

endmodule
